csr_mfile_ext: RTL

//  M-mode CSR file for the write-back stage; successor to the fixed single-hart CSR set.

---
 rtl/csr_mfile_ext_if.sv | 33 +++
 rtl/csr_mfile_ext.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/csr_mfile_ext_if.sv
// ---------------------------------------------------------------------------
// csr_mfile_ext_if
// CSR access bus between the pipeline and the M-mode CSR file.
//   rd_index   decode-stage read address
//   rd_data    combinational read data (0 for an unimplemented address)
//   rd_illegal read address has no CSR behind it
//   wr_en      a CSR instruction commits this cycle
//   wr_op      01 write, 10 set, 11 clear, 00 no-op
//   wr_index   write address
//   wr_wdata   rs1 / zimm operand
//   wr_illegal write targets an unimplemented or read-only address
// master: pipeline side, slave: CSR file side.
// ---------------------------------------------------------------------------
interface csr_mfile_ext_if;
    logic [11:0] rd_index;
    logic [31:0] rd_data;
    logic        rd_illegal;
    logic        wr_en;
    logic [1:0]  wr_op;
    logic [11:0] wr_index;
    logic [31:0] wr_wdata;
    logic        wr_illegal;

    modport master (
        output rd_index, wr_en, wr_op, wr_index, wr_wdata,
        input  rd_data, rd_illegal, wr_illegal
    );

    modport slave (
        input  rd_index, wr_en, wr_op, wr_index, wr_wdata,
        output rd_data, rd_illegal, wr_illegal
    );
endinterface

// File: rtl/csr_mfile_ext.sv
// ---------------------------------------------------------------------------
// csr_mfile_ext
// Machine-mode CSR file sitting in the write-back stage. CSRRW/S/C are
// applied here, traps and MRET update mstatus/mepc/mcause/mtval, and the
// 64-bit mcycle/minstret plus NUM_HPM event counters run continuously unless
// inhibited through mcountinhibit. Reads for decode are purely combinational.
// Ports:
//   clk, cpurst              clock (rising edge), async active-high reset
//   bus                      CSR read/write bus (csr_mfile_ext_if.slave)
//   trap_exc, trap_int       exception / interrupt commit
//   trap_cause, trap_pc,
//   trap_tval                cause code, mepc value, mtval value
//   mret                     MRET commits
//   retire                   one instruction retired this cycle
//   hpm_evt                  per-HPM-counter event pulses
//   irq_ext, irq_tmr, irq_sw level interrupt lines feeding mip
//   irq_req                  enabled interrupt pending
//   mstatus..mip             current CSR values for the pipeline
// ---------------------------------------------------------------------------
module csr_mfile_ext #(
    parameter int          NUM_HPM   = 3,
    parameter logic [31:0] HART_ID   = 32'h0,
    parameter logic [31:0] MTVEC_RST = 32'h0,
    parameter bit          VECTORED  = 1'b1
) (
    input  logic        clk,
    input  logic        cpurst,
    csr_mfile_ext_if.slave bus,
    input  logic        trap_exc,
    input  logic        trap_int,
    input  logic [4:0]  trap_cause,
    input  logic [31:0] trap_pc,
    input  logic [31:0] trap_tval,
    input  logic        mret,
    input  logic        retire,
    input  logic [((NUM_HPM > 0) ? NUM_HPM : 1)-1:0] hpm_evt,
    input  logic        irq_ext,
    input  logic        irq_tmr,
    input  logic        irq_sw,
    output logic        irq_req,
    output logic [31:0] mstatus,
    output logic [31:0] mie,
    output logic [31:0] mtvec,
    output logic [31:0] mepc,
    output logic [31:0] mcause,
    output logic [31:0] mtval,
    output logic [31:0] mip
);

    // Arrays keep at least one entry so NUM_HPM=0 still elaborates.
    localparam int HPM_W = (NUM_HPM > 0) ? NUM_HPM : 1;

    localparam logic [1:0]  MTVEC_MODE = VECTORED ? 2'b01 : 2'b00;
    localparam logic [31:0] MIE_MASK   = 32'h0000_0888;

    // Writable mcountinhibit bits: CY, IR and one per implemented HPM counter.
    function automatic logic [31:0] inhibit_mask();
        logic [31:0] m;
        m = 32'h0000_0005;
        for (int i = 0; i < NUM_HPM; i++) begin
            m[3+i] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [31:0] CINH_MASK = inhibit_mask();

    typedef struct packed {
        logic [31:0] data;
        logic        hit;
        logic        ro;
    } csr_look_t;

    logic        st_mie;
    logic        st_mpie;
    logic [31:0] mscratch;
    logic [31:0] mcountinhibit;
    logic [63:0] mcycle_q;
    logic [63:0] minstret_q;
    logic [63:0] hpm_q [HPM_W];

    csr_look_t   rd_look;
    csr_look_t   wr_look;
    logic [31:0] wr_new;
    logic        trap_any;
    logic        wr_do;

    logic        cy_wr_lo;
    logic        cy_wr_hi;
    logic        ir_wr_lo;
    logic        ir_wr_hi;
    logic        hpm_wr_lo [HPM_W];
    logic        hpm_wr_hi [HPM_W];
    logic        hpm_inc   [HPM_W];

    // mstatus only holds MIE and MPIE; MPP is hard-wired to machine mode.
    assign mstatus = {19'b0, 2'b11, 3'b0, st_mpie, 3'b0, st_mie, 3'b0};

    // mip is a straight view of the interrupt lines, so it follows them
    // even while the block is held in reset.
    assign mip = {20'b0, irq_ext, 3'b0, irq_tmr, 3'b0, irq_sw, 3'b0};

    assign irq_req = st_mie & (|(mip & mie));

    // Address decode shared by the read port and the write port: returns the
    // current value, whether the address exists, and whether it is read-only.
    function automatic csr_look_t lookup(input logic [11:0] idx);
        csr_look_t r;
        r      = '0;
        r.hit  = 1'b1;
        case (idx)
            12'h300: r.data = mstatus;
            12'h304: r.data = mie;
            12'h305: r.data = mtvec;
            12'h320: r.data = mcountinhibit;
            12'h340: r.data = mscratch;
            12'h341: r.data = mepc;
            12'h342: r.data = mcause;
            12'h343: r.data = mtval;
            12'h344: begin
                r.data = mip;
                r.ro   = 1'b1;
            end
            12'hF14: begin
                r.data = HART_ID;
                r.ro   = 1'b1;
            end
            12'hB00: r.data = mcycle_q[31:0];
            12'hB80: r.data = mcycle_q[63:32];
            12'hB02: r.data = minstret_q[31:0];
            12'hB82: r.data = minstret_q[63:32];
            default: begin
                r.hit = 1'b0;
                for (int i = 0; i < NUM_HPM; i++) begin
                    if (idx == 12'hB03 + 12'(i)) begin
                        r.hit  = 1'b1;
                        r.data = hpm_q[i][31:0];
                    end
                    if (idx == 12'hB83 + 12'(i)) begin
                        r.hit  = 1'b1;
                        r.data = hpm_q[i][63:32];
                    end
                end
            end
        endcase
        return r;
    endfunction

    // Decode both ports; unimplemented reads return zero.
    always_comb begin
        rd_look = lookup(bus.rd_index);
        wr_look = lookup(bus.wr_index);
    end

    assign bus.rd_data    = rd_look.hit ? rd_look.data : 32'h0;
    assign bus.rd_illegal = ~rd_look.hit;
    assign bus.wr_illegal = bus.wr_en & (~wr_look.hit | wr_look.ro);

    // Read-modify-write value for CSRRW/CSRRS/CSRRC against the old value.
    always_comb begin
        wr_new = wr_look.data;
        case (bus.wr_op)
            2'b01:   wr_new = bus.wr_wdata;
            2'b10:   wr_new = wr_look.data | bus.wr_wdata;
            2'b11:   wr_new = wr_look.data & ~bus.wr_wdata;
            default: wr_new = wr_look.data;
        endcase
    end

    // A trap or MRET in the same cycle swallows the CSR write completely.
    assign trap_any = trap_exc | trap_int;
    assign wr_do    = bus.wr_en & (bus.wr_op != 2'b00) & ~bus.wr_illegal
                    & ~trap_any & ~mret;

    assign cy_wr_lo = wr_do & (bus.wr_index == 12'hB00);
    assign cy_wr_hi = wr_do & (bus.wr_index == 12'hB80);
    assign ir_wr_lo = wr_do & (bus.wr_index == 12'hB02);
    assign ir_wr_hi = wr_do & (bus.wr_index == 12'hB82);

    // Per-HPM write strobes and gated event increments.
    always_comb begin
        for (int i = 0; i < HPM_W; i++) begin
            hpm_wr_lo[i] = 1'b0;
            hpm_wr_hi[i] = 1'b0;
            hpm_inc[i]   = 1'b0;
            if (i < NUM_HPM) begin
                hpm_wr_lo[i] = wr_do & (bus.wr_index == 12'hB03 + 12'(i));
                hpm_wr_hi[i] = wr_do & (bus.wr_index == 12'hB83 + 12'(i));
                hpm_inc[i]   = hpm_evt[i] & ~mcountinhibit[3+i];
            end
        end
    end

    // A written half replaces only that half and suppresses the increment,
    // so a written low half never carries into the high half.
    function automatic logic [63:0] cnt_next(input logic [63:0] c,
                                             input logic        inc,
                                             input logic        wlo,
                                             input logic        whi,
                                             input logic [31:0] d);
        if (wlo) begin
            return {c[63:32], d};
        end
        if (whi) begin
            return {d, c[31:0]};
        end
        if (inc) begin
            return c + 64'd1;
        end
        return c;
    endfunction

    // Control/status registers: trap beats MRET, MRET beats a CSR write.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            st_mie        <= 1'b0;
            st_mpie       <= 1'b0;
            mie           <= 32'h0;
            mtvec         <= {MTVEC_RST[31:2], MTVEC_MODE};
            mepc          <= 32'h0;
            mcause        <= 32'h0;
            mtval         <= 32'h0;
            mscratch      <= 32'h0;
            mcountinhibit <= 32'h0;
        end else if (trap_any) begin
            st_mpie <= st_mie;
            st_mie  <= 1'b0;
            mepc    <= trap_pc;
            mcause  <= {trap_int, 26'b0, trap_cause};
            if (trap_exc) begin
                mtval <= trap_tval;
            end
        end else if (mret) begin
            st_mie  <= st_mpie;
            st_mpie <= 1'b1;
        end else if (wr_do) begin
            case (bus.wr_index)
                12'h300: begin
                    st_mie  <= wr_new[3];
                    st_mpie <= wr_new[7];
                end
                12'h304: mie           <= wr_new & MIE_MASK;
                12'h305: mtvec         <= {wr_new[31:2], MTVEC_MODE};
                12'h320: mcountinhibit <= wr_new & CINH_MASK;
                12'h340: mscratch      <= wr_new;
                12'h341: mepc          <= wr_new;
                12'h342: mcause        <= wr_new;
                12'h343: mtval         <= wr_new;
                default: ;
            endcase
        end
    end

    // Free-running counters; they keep counting through traps and MRET.
    always_ff @(posedge clk or posedge cpurst) begin
        if (cpurst) begin
            mcycle_q   <= 64'h0;
            minstret_q <= 64'h0;
            for (int i = 0; i < HPM_W; i++) begin
                hpm_q[i] <= 64'h0;
            end
        end else begin
            mcycle_q   <= cnt_next(mcycle_q, ~mcountinhibit[0],
                                   cy_wr_lo, cy_wr_hi, wr_new);
            minstret_q <= cnt_next(minstret_q, retire & ~mcountinhibit[2],
                                   ir_wr_lo, ir_wr_hi, wr_new);
            for (int i = 0; i < HPM_W; i++) begin
                hpm_q[i] <= cnt_next(hpm_q[i], hpm_inc[i],
                                     hpm_wr_lo[i], hpm_wr_hi[i], wr_new);
            end
        end
    end

endmodule
